dmem_responder: RTL and testbench

- Data-memory responder serving the MEM stage of the 5-stage pipelined MIPS CPU.
- Sits on the far end of the controller's mem_ren/mem_wen request interface.
- Services word loads and stores against an internal single-port RAM with a configurable number of wait states.
- Returns mem_stall so the pipeline controller can freeze IF..MEM while an access is in flight.

---
 rtl/dmem_responder_pkg.sv | 25 ++
 rtl/dmem_array.sv | 26 ++
 rtl/dmem_responder.sv | 121 ++++++++++++
 tb/tb_dmem_responder.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared types and helpers for the data-memory responder.
// Holds the FSM encoding and the request legality rule.
package dmem_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } dmem_state_t;

    localparam int CNT_W = 4;

    // Both ops at once, misaligned, or beyond the RAM's byte range.
    function automatic logic req_illegal(
        input logic        ren,
        input logic        wen,
        input logic [31:0] addr,
        input int          aw
    );
        logic [31:0] hi;
        hi = addr >> (aw + 2);
        return (ren & wen) | (addr[1:0] != 2'b00) | (hi != 32'd0);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous 32-bit RAM with registered read data.
// No reset: contents survive a pipeline reset.
module dmem_array #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           din,
    output logic [31:0]           dout
);

    logic [31:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= din;
            end else begin
                dout <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data-memory responder: latches a load/store request,
// waits WAIT_CYCLES, commits to the RAM and stalls the pipeline meanwhile.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_ren,
    input  logic        mem_wen,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_stall,
    output logic        mem_err,
    output logic [31:0] access_count
);

    dmem_state_t state, state_nx;

    logic [CNT_W-1:0]      cnt;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           wdata_q;
    logic                  wr_q;
    logic                  ill_q;
    logic [31:0]           rdata_q;
    logic [31:0]           ram_dout;

    logic req;
    logic ill;
    logic commit;
    logic rd_ok;

    assign req    = mem_ren | mem_wen;
    assign ill    = req_illegal(mem_ren, mem_wen, mem_addr, ADDR_WIDTH);
    assign commit = (state == ST_WAIT) && (cnt == '0);
    assign rd_ok  = !ill_q && !wr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        mem_stall = 1'b0;
        mem_err   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                mem_stall = req;
                if (req) state_nx = ST_WAIT;
            end
            ST_WAIT: begin
                mem_stall = 1'b1;
                if (cnt == '0) state_nx = ST_DONE;
            end
            ST_DONE: begin
                mem_err  = ill_q;
                state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt          <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wr_q         <= 1'b0;
            ill_q        <= 1'b0;
            rdata_q      <= '0;
            access_count <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (req) begin
                        addr_q  <= mem_addr[ADDR_WIDTH+1:2];
                        wdata_q <= mem_wdata;
                        wr_q    <= mem_wen;
                        ill_q   <= ill;
                        cnt     <= CNT_W'(WAIT_CYCLES);
                    end
                end
                ST_WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (ill_q) begin
                        rdata_q <= '0;
                    end else begin
                        access_count <= access_count + 32'd1;
                    end
                end
                ST_DONE: begin
                    // Fold the RAM's registered output into the held copy.
                    if (rd_ok) rdata_q <= ram_dout;
                end
                default: ;
            endcase
        end
    end

    dmem_array #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_array (
        .clk  (clk),
        .en   (commit && !ill_q && !rst),
        .we   (wr_q),
        .addr (addr_q),
        .din  (wdata_q),
        .dout (ram_dout)
    );

    assign mem_rdata = (state == ST_DONE && rd_ok) ? ram_dout : rdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized scoreboard bench for dmem_responder.
// A word-array model predicts each response; a monitor checks DONE cycles.
module tb_dmem_responder;

    localparam int AW = 10;
    localparam int WC = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        ren;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        stall;
    logic        err;
    logic [31:0] count;

    always #5 clk = ~clk;

    dmem_responder #(
        .ADDR_WIDTH (AW),
        .WAIT_CYCLES(WC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_ren     (ren),
        .mem_wen     (wen),
        .mem_addr    (addr),
        .mem_wdata   (wdata),
        .mem_rdata   (rdata),
        .mem_stall   (stall),
        .mem_err     (err),
        .access_count(count)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic [31:0] count;
    } exp_t;

    exp_t sbq[$];

    int compared   = 0;
    int mismatched = 0;

    logic [31:0] model_mem [int];
    logic [31:0] last_rd;
    logic [31:0] model_cnt;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: measures each stall run and checks the DONE cycle after it.
    int run = 0;
    always @(negedge clk) begin
        if (rst) begin
            run = 0;
        end else if (stall) begin
            run++;
            check("err_while_stalled", 32'(err), 32'd0);
        end else if (run > 0) begin
            exp_t e;
            check("stall_len", 32'(run), 32'(WC + 2));
            if (sbq.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_done: got a DONE cycle, required none");
            end else begin
                e = sbq.pop_front();
                check("rdata", rdata, e.rdata);
                check("err", 32'(err), 32'(e.err));
                check("access_count", count, e.count);
            end
            run = 0;
        end else begin
            check("err_idle", 32'(err), 32'd0);
        end
    end

    // Issue one request, predict its response, hold it until DONE.
    task automatic do_req(input logic r, input logic w,
                          input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        bit   ill;
        bit   done;
        int   idx;
        idx = int'(a[AW+1:2]);
        ill = (r && w) || (a % 4 != 0) || (a >= 32'(4 * (2 ** AW)));
        if (ill) begin
            last_rd = 32'd0;
            e.rdata = 32'd0;
            e.err   = 1'b1;
        end else if (w) begin
            model_mem[idx] = d;
            e.rdata = last_rd;
            e.err   = 1'b0;
            model_cnt++;
        end else begin
            last_rd = model_mem.exists(idx) ? model_mem[idx] : 32'd0;
            e.rdata = last_rd;
            e.err   = 1'b0;
            model_cnt++;
        end
        e.count = model_cnt;
        sbq.push_back(e);
        ren   = r;
        wen   = w;
        addr  = a;
        wdata = d;
        done  = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (!stall) begin
                done = 1;
                break;
            end
        end
        if (!done) begin
            compared++;
            mismatched++;
            $display("FAIL timeout: stall still high after 40 cycles, required DONE");
        end
        @(posedge clk);
        #1;
        ren = 1'b0;
        wen = 1'b0;
        repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        @(negedge clk);
        check({tag, "_stall"}, 32'(stall), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
        check({tag, "_rdata"}, rdata, 32'd0);
        check({tag, "_count"}, count, 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Store whose access is aborted by reset in its second WAIT cycle.
    task automatic reset_during_wait(input logic [31:0] a, input logic [31:0] d);
        ren   = 1'b0;
        wen   = 1'b1;
        addr  = a;
        wdata = d;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        wen = 1'b0;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        model_cnt = 32'd0;
        last_rd   = 32'd0;
        check_reset_outputs("abort");
    endtask

    initial begin
        rst       = 1'b1;
        ren       = 1'b0;
        wen       = 1'b0;
        addr      = 32'd0;
        wdata     = 32'd0;
        model_cnt = 32'd0;
        last_rd   = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_outputs("reset");

        for (int i = 0; i < 32; i++) do_req(1'b0, 1'b1, 32'(i * 4), $urandom);

        do_req(1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
        do_req(1'b1, 1'b0, 32'h10, 32'h0);
        do_req(1'b1, 1'b0, 32'h13, 32'h0);
        do_req(1'b0, 1'b1, 32'h1000, 32'hCAFEF00D);
        do_req(1'b1, 1'b0, 32'h0, 32'h0);
        do_req(1'b1, 1'b1, 32'h10, 32'h11111111);
        do_req(1'b1, 1'b0, 32'h10, 32'h0);

        reset_during_wait(32'h20, 32'h12345678);
        do_req(1'b1, 1'b0, 32'h20, 32'h0);

        for (int n = 0; n < 150; n++) begin
            int          sel;
            int          idx;
            logic [31:0] a;
            logic        r;
            sel = $urandom_range(0, 9);
            idx = $urandom_range(0, 31);
            r   = 1'($urandom_range(0, 1));
            a   = 32'(idx * 4);
            if (sel <= 3) do_req(1'b1, 1'b0, a, 32'h0);
            else if (sel <= 6) do_req(1'b0, 1'b1, a, $urandom);
            else if (sel == 7) do_req(r, !r, a + 32'($urandom_range(1, 3)), $urandom);
            else if (sel == 8) do_req(r, !r, a | (32'($urandom_range(1, 'hFFFFF)) << 12), $urandom);
            else do_req(1'b1, 1'b1, a, $urandom);
        end

        repeat (3) @(posedge clk);
        check("queue_empty", 32'(sbq.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
